// File: rtl/regfile_arbiter.sv
// Two-requester arbiter for a single-port 16x8 register file: req/ack handshake, round-robin ties.
// Define RF_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of alternating.
module regfile_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int WA_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [WA_W-1:0]   rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [DATA_W-1:0] rf_rd1
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic                winner_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;

  logic                grant_valid;
  logic                grant_id;
  logic                grant_we;
  logic [ADDR_W-1:0]   grant_addr;
  logic [DATA_W-1:0]   grant_wdata;
  logic [1:0]          ack_vec;

`ifndef RF_ARB_FIXED_PRIO_EN
  logic                last_grant_reg;
`endif

  // Arbitration is only consulted in IDLE; requests are ignored in every other state.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = 1'b0;
    if (req0 && req1) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      grant_id = 1'b0;
`else
      grant_id = ~last_grant_reg;
`endif
    end else if (req1) begin
      grant_id = 1'b1;
    end
    grant_we    = grant_id ? we1    : we0;
    grant_addr  = grant_id ? addr1  : addr0;
    grant_wdata = grant_id ? wdata1 : wdata0;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = grant_we ? WR : RD_ADDR;
      WR:      state_next = DONE;
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      winner_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && grant_valid) begin
        winner_reg <= grant_id;
        addr_reg   <= grant_addr;
        wdata_reg  <= grant_wdata;
      end
      if (state_reg == RD_DATA) begin
        rdata_reg <= rf_rd1;
      end
    end
  end

`ifndef RF_ARB_FIXED_PRIO_EN
  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_reg <= 1'b1;
    end else if (state_reg == IDLE && grant_valid) begin
      last_grant_reg <= grant_id;
    end
  end
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_ack
    assign ack_vec[gi] = (state_reg == DONE) && (winner_reg == 1'(gi));
  end

  assign ack0  = ack_vec[0];
  assign ack1  = ack_vec[1];
  assign busy  = (state_reg != IDLE);
  assign rdata = rdata_reg;

  // Register-file pins come only from state and the latched command, never from req inputs.
  assign rf_we = (state_reg == WR);
  assign rf_a1 = addr_reg;
  assign rf_wa = {{(WA_W-ADDR_W){1'b0}}, addr_reg};
  assign rf_wd = wdata_reg;

endmodule
